// File: rtl/axis_wide_to_narrow_tx_pkg.sv
// Shared constants, state type and helpers for the AXI4-Stream wide-to-narrow transmitter.
package axis_tx_pkg;

  localparam int unsigned AXIS_DEST_W   = 4;
  localparam int unsigned AXIS_ID_W     = 16;
  localparam int unsigned AXIS_USER_W   = 4;
  localparam logic        AXIS_KEEP_ALL = 1'b1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  function automatic int unsigned ratio(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/axis_wide_to_narrow_tx_hold_reg.sv
// Wide holding register with a full flag; a load in the same cycle as a clear wins.
module axis_hold_reg #(
  parameter int unsigned W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = din;
      full_d = 1'b1;
    end else if (clr) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/axis_wide_to_narrow_tx.sv
// Serialises IN_W words into OUT_W AXI4-Stream beats (LSB slice first) with programmable TLAST framing.
// Define AXIS_TX_SKID_EN to add a second holding register for back-to-back words at full throughput.
module axis_wide_to_narrow_tx
  import axis_tx_pkg::*;
#(
  parameter int unsigned IN_W     = 256,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned DEST_VAL = 0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [IN_W-1:0]        s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LEN_W-1:0]       cfg_pkt_words,
  output logic [OUT_W-1:0]       m_axis_tdata,
  output logic [OUT_W/8-1:0]     m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [AXIS_DEST_W-1:0] m_axis_tdest,
  output logic [AXIS_ID_W-1:0]   m_axis_tid,
  output logic [AXIS_USER_W-1:0] m_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   busy
);

  localparam int unsigned RATIO  = ratio(IN_W, OUT_W);
  localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  if ((OUT_W == 0) || (IN_W < OUT_W) || ((IN_W % OUT_W) != 0)) begin : g_bad_width
    $fatal(1, "axis_wide_to_narrow_tx: IN_W (%0d) must be an integer multiple of OUT_W (%0d)", IN_W, OUT_W);
  end

  tx_state_e          state_q, state_d;
  logic [IN_W-1:0]    sh_q, sh_d;
  logic [BEAT_W-1:0]  beat_idx_q, beat_idx_d;
  logic [LEN_W-1:0]   word_idx_q, word_idx_d;
  logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
  logic               ready_en_q;

  logic               sh_full;
  logic               in_hs;
  logic               out_hs;
  logic               last_beat;
  logic               last_word;
  logic               word_done;
  logic               sh_load;
  logic [IN_W-1:0]    sh_load_data;

  assign sh_full   = (state_q == TX_SEND);
  assign in_hs     = s_valid && s_ready;
  assign out_hs    = sh_full && m_axis_tready;
  assign last_beat = (beat_idx_q == LAST_BEAT);
  assign last_word = (word_idx_q == (pkt_len_q - 1'b1));
  assign word_done = out_hs && last_beat;

`ifdef AXIS_TX_SKID_EN
  logic            hold_load;
  logic            hold_clr;
  logic            hold_full;
  logic [IN_W-1:0] hold_data;

  assign s_ready = ready_en_q && !hold_full;

  // A new word goes straight into sh when sh is free (or freeing with hold empty); otherwise it parks
  // in hold. Hold is never full while sh is empty, so hold always drains first on a word-done.
  always_comb begin
    sh_load      = 1'b0;
    sh_load_data = s_data;
    hold_load    = 1'b0;
    hold_clr     = 1'b0;
    if (!sh_full) begin
      sh_load = in_hs;
    end else if (word_done) begin
      if (hold_full) begin
        sh_load      = 1'b1;
        sh_load_data = hold_data;
        hold_clr     = 1'b1;
        hold_load    = in_hs;
      end else begin
        sh_load = in_hs;
      end
    end else begin
      hold_load = in_hs;
    end
  end

  axis_hold_reg #(
    .W (IN_W)
  ) u_hold (
    .clk   (aclk),
    .rst_n (aresetn),
    .load  (hold_load),
    .clr   (hold_clr),
    .din   (s_data),
    .dout  (hold_data),
    .full  (hold_full)
  );
`else
  assign s_ready      = ready_en_q && !sh_full;
  assign sh_load      = in_hs;
  assign sh_load_data = s_data;
`endif

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    beat_idx_d = beat_idx_q;
    word_idx_d = word_idx_q;
    pkt_len_d  = pkt_len_q;

    case (state_q)
      TX_IDLE: begin
        if (sh_load) begin
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (out_hs) begin
          sh_d       = sh_q >> OUT_W;
          beat_idx_d = beat_idx_q + 1'b1;
          if (last_beat) begin
            beat_idx_d = '0;
            word_idx_d = last_word ? '0 : word_idx_q + 1'b1;
            if (!sh_load) begin
              state_d = TX_IDLE;
            end
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Length is latched by whichever word becomes word 0, including a reload at the tlast handshake.
    if (sh_load) begin
      sh_d       = sh_load_data;
      beat_idx_d = '0;
      if (word_idx_d == '0) begin
        pkt_len_d = (cfg_pkt_words == '0) ? LEN_W'(1) : cfg_pkt_words;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= TX_IDLE;
      sh_q       <= '0;
      beat_idx_q <= '0;
      word_idx_q <= '0;
      pkt_len_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      beat_idx_q <= beat_idx_d;
      word_idx_q <= word_idx_d;
      pkt_len_q  <= pkt_len_d;
      ready_en_q <= 1'b1;
    end
  end

  assign m_axis_tdata  = sh_q[OUT_W-1:0];
  assign m_axis_tvalid = sh_full;
  assign m_axis_tlast  = sh_full && last_beat && last_word;
  assign m_axis_tkeep  = {(OUT_W/8){AXIS_KEEP_ALL}};
  assign m_axis_tdest  = AXIS_DEST_W'(DEST_VAL);
  assign m_axis_tid    = '0;
  assign m_axis_tuser  = '0;
  assign busy          = (word_idx_q != '0) || sh_full;

endmodule
